mem_stage: RTL and testbench

Memory stage of the five-stage pipeline. It sits directly downstream of the execute/memory latch and consumes that latch's M-side outputs. It sequences one load or store per instruction against the multi-cycle data cache and raises `dstall` while the access is outstanding. It selects the writeback value and registers the result into the memory/writeback boundary consumed by the register file.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_m2w_ff.sv | 86 ++++++++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage_pkg                                                |
// | Description : Shared types and constants for the pipeline memory stage:    |
// |               access-sequencer state encoding, writeback source codes,     |
// |               alignment-check default and the writeback source mux.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_stage_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // ready to issue the current instruction's access
    ST_WAIT = 2'b01,  // request accepted, waiting for the cache to finish
    ST_HOLD = 2'b10   // access served, pipeline frozen by the fetch side
  } state_e;

  // Writeback source select codes
  localparam logic [1:0] WB_SEL_MEM = 2'd0;
  localparam logic [1:0] WB_SEL_ALU = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  // Odd-address memory ops are rejected unless this is cleared
  localparam bit CHECK_ALIGN_DEFAULT = 1'b1;

  function automatic logic [15:0] wb_select(
    input logic [1:0]  sel,
    input logic [15:0] rd_data,
    input logic [15:0] alu_final,
    input logic [15:0] add_pc,
    input logic [15:0] imm8
  );
    logic [15:0] res;
    case (sel)
      WB_SEL_MEM: res = rd_data;
      WB_SEL_ALU: res = alu_final;
      WB_SEL_PC:  res = add_pc;
      default:    res = imm8;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_m2w_ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m2w_ff                                                       |
// | Description : Memory/writeback boundary register bank. On load it captures |
// |               the complete writeback record; otherwise it inserts a bubble |
// |               (write enable, dump and error cleared, payload kept).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   load                1 = capture record, 0 = bubble
//   wb_data_i .. instr_i  incoming writeback record
//   wbDataW .. instructionW  registered writeback record
module m2w_ff
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] wb_data_i,
  input  logic        reg_wrt_i,
  input  logic [2:0]  wrt_reg_i,
  input  logic        create_dump_i,
  input  logic        err_i,
  input  logic [15:0] instr_i,
  output logic [15:0] wbDataW,
  output logic        regWrtW,
  output logic [2:0]  wrtRegW,
  output logic        createDumpW,
  output logic        errW,
  output logic [15:0] instructionW
);

  logic [15:0] wb_data_q, wb_data_d;
  logic        reg_wrt_q, reg_wrt_d;
  logic [2:0]  wrt_reg_q, wrt_reg_d;
  logic        create_dump_q, create_dump_d;
  logic        err_q, err_d;
  logic [15:0] instr_q, instr_d;

  always_comb begin
    // Bubble by default: side-effect bits cleared so a frozen instruction
    // cannot retire twice; payload fields simply hold.
    wb_data_d     = wb_data_q;
    reg_wrt_d     = 1'b0;
    wrt_reg_d     = wrt_reg_q;
    create_dump_d = 1'b0;
    err_d         = 1'b0;
    instr_d       = instr_q;
    if (load) begin
      wb_data_d     = wb_data_i;
      reg_wrt_d     = reg_wrt_i;
      wrt_reg_d     = wrt_reg_i;
      create_dump_d = create_dump_i;
      err_d         = err_i;
      instr_d       = instr_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_q     <= 16'h0000;
      reg_wrt_q     <= 1'b0;
      wrt_reg_q     <= 3'b000;
      create_dump_q <= 1'b0;
      err_q         <= 1'b0;
      instr_q       <= 16'h0000;
    end else begin
      wb_data_q     <= wb_data_d;
      reg_wrt_q     <= reg_wrt_d;
      wrt_reg_q     <= wrt_reg_d;
      create_dump_q <= create_dump_d;
      err_q         <= err_d;
      instr_q       <= instr_d;
    end
  end

  assign wbDataW      = wb_data_q;
  assign regWrtW      = reg_wrt_q;
  assign wrtRegW      = wrt_reg_q;
  assign createDumpW  = create_dump_q;
  assign errW         = err_q;
  assign instructionW = instr_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage                                                    |
// | Description : Pipeline memory stage. Issues one load/store per instruction |
// |               to a multi-cycle data cache, stalls upstream while the       |
// |               access is outstanding, selects the writeback value and       |
// |               registers it into the memory/writeback boundary.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   *M inputs                   execute/memory latch outputs (aluOutM = address)
//   istall                      fetch-side stall, freezes the whole pipeline
//   memAddr/memDataIn/memRd/memWr      cache request
//   memDataOut/memDone/memStall/memErr cache response
//   dstall                      data-side stall to upstream latches
//   *W outputs                  registered writeback record
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit CHECK_ALIGN = CHECK_ALIGN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluFinalM,
  input  logic [15:0] addPCM,
  input  logic [15:0] aluOutM,
  input  logic [15:0] wrtDataM,
  input  logic [15:0] imm8M,
  input  logic [15:0] instructionM,
  input  logic        memWrtM,
  input  logic        readEnM,
  input  logic [1:0]  wbDataSelM,
  input  logic        regWrtM,
  input  logic [2:0]  wrtRegM,
  input  logic        createDumpM,
  input  logic        istall,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  output logic        memRd,
  output logic        memWr,
  input  logic [15:0] memDataOut,
  input  logic        memDone,
  input  logic        memStall,
  input  logic        memErr,
  output logic        dstall,
  output logic [15:0] wbDataW,
  output logic        regWrtW,
  output logic [2:0]  wrtRegW,
  output logic        createDumpW,
  output logic        errW,
  output logic [15:0] instructionW
);

  state_e      state_q, state_d;
  logic [15:0] rd_hold_q, rd_hold_d;
  logic        sticky_q, sticky_d;

  logic        memop;
  logic        misalign;
  logic        req;        // request driven this cycle (before reset gating)
  logic        stall_c;    // stall condition (before reset gating)
  logic        complete;   // cache finishes the access this cycle
  logic        in_hold;
  logic        advance;
  logic        err_now;
  logic [15:0] rd_data;
  logic [15:0] wb_data;
  logic        err_w;

  assign memop    = memWrtM | readEnM;
  assign misalign = CHECK_ALIGN & memop & aluOutM[0];

  // Sequencer: next state and per-cycle request/stall decisions
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    stall_c  = 1'b0;
    complete = 1'b0;
    in_hold  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memop && !misalign) begin
          req = 1'b1;
          if (memStall) begin
            // Not accepted: keep presenting the same request
            stall_c = 1'b1;
          end else if (memDone) begin
            complete = 1'b1;
            if (istall) state_d = ST_HOLD;
          end else begin
            stall_c = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (memDone) begin
          complete = 1'b1;
          state_d  = istall ? ST_HOLD : ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      ST_HOLD: begin
        in_hold = 1'b1;
        if (!istall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The request and stall are combinational from the held M inputs, so they
  // are masked directly by reset to stay quiet while it is asserted.
  assign memRd     = rst & req & readEnM;
  assign memWr     = rst & req & memWrtM;
  assign memAddr   = (rst & req) ? aluOutM  : 16'h0000;
  assign memDataIn = (rst & req) ? wrtDataM : 16'h0000;
  assign dstall    = rst & stall_c;

  assign advance = ~istall & ~dstall;

  // Captured on every completion (hit or miss) so a frozen pipeline in HOLD
  // still sees the served data after memDataOut has moved on.
  assign rd_hold_d = complete ? memDataOut : rd_hold_q;
  assign rd_data   = in_hold ? rd_hold_q : memDataOut;
  assign wb_data   = wb_select(wbDataSelM, rd_data, aluFinalM, addPCM, imm8M);

  assign err_now  = complete & memErr;
  assign sticky_d = advance ? 1'b0 : (sticky_q | err_now);
  assign err_w    = misalign | err_now | sticky_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rd_hold_q <= 16'h0000;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_hold_q <= rd_hold_d;
      sticky_q  <= sticky_d;
    end
  end

  m2w_ff u_m2w_ff (
    .clk           (clk),
    .rst           (rst),
    .load          (advance),
    .wb_data_i     (wb_data),
    .reg_wrt_i     (regWrtM),
    .wrt_reg_i     (wrtRegM),
    .create_dump_i (createDumpM),
    .err_i         (err_w),
    .instr_i       (instructionM),
    .wbDataW       (wbDataW),
    .regWrtW       (regWrtW),
    .wrtRegW       (wrtRegW),
    .createDumpW   (createDumpW),
    .errW          (errW),
    .instructionW  (instructionW)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage                                                 |
// | Description : Self-checking bench for mem_stage. Each instruction is a     |
// |               scenario (cache stall cycles, miss latency, fetch-stall      |
// |               length); the expected cycle-by-cycle behaviour is derived    |
// |               from the scenario timeline, not from the design's FSM.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;

  logic        clk;
  logic        rst;
  logic [15:0] aluFinalM, addPCM, aluOutM, wrtDataM, imm8M, instructionM;
  logic        memWrtM, readEnM;
  logic [1:0]  wbDataSelM;
  logic        regWrtM;
  logic [2:0]  wrtRegM;
  logic        createDumpM;
  logic        istall;
  logic [15:0] memAddr, memDataIn;
  logic        memRd, memWr;
  logic [15:0] memDataOut;
  logic        memDone, memStall, memErr;
  logic        dstall;
  logic [15:0] wbDataW;
  logic        regWrtW;
  logic [2:0]  wrtRegW;
  logic        createDumpW, errW;
  logic [15:0] instructionW;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .aluFinalM(aluFinalM), .addPCM(addPCM), .aluOutM(aluOutM),
    .wrtDataM(wrtDataM), .imm8M(imm8M), .instructionM(instructionM),
    .memWrtM(memWrtM), .readEnM(readEnM), .wbDataSelM(wbDataSelM),
    .regWrtM(regWrtM), .wrtRegM(wrtRegM), .createDumpM(createDumpM),
    .istall(istall),
    .memAddr(memAddr), .memDataIn(memDataIn), .memRd(memRd), .memWr(memWr),
    .memDataOut(memDataOut), .memDone(memDone), .memStall(memStall), .memErr(memErr),
    .dstall(dstall),
    .wbDataW(wbDataW), .regWrtW(regWrtW), .wrtRegW(wrtRegW),
    .createDumpW(createDumpW), .errW(errW), .instructionW(instructionW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr, alu, pc, imm, wdata, instr, rdata;
    logic [1:0]  sel;
    logic        regwrt;
    logic [2:0]  wreg;
    logic        dump;
    logic        ebit;
    int          s, n, k;       // memStall cycles, miss latency, istall cycles
    logic [15:0] exp_wb;
    logic        exp_err;
    int          exp_dst;       // cycles with dstall high
    int          exp_req;       // cycles with memRd/memWr high
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] prev_wb = 16'h0000;
  vec_t        tab [10];
  vec_t        rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] op, input logic [15:0] addr, input logic [1:0] sel,
    input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] imm,
    input logic [15:0] rdata, input int s, input int n, input int k,
    input logic ebit, input logic [2:0] wreg,
    input logic [15:0] exp_wb, input logic exp_err, input int exp_dst, input int exp_req);
    vec_t v;
    v.op = op; v.addr = addr; v.sel = sel; v.alu = alu; v.pc = pc; v.imm = imm;
    v.rdata = rdata; v.s = s; v.n = n; v.k = k; v.ebit = ebit; v.wreg = wreg;
    v.wdata = addr ^ 16'h5A5A; v.instr = alu ^ 16'hF00F; v.regwrt = 1'b1; v.dump = 1'b0;
    v.exp_wb = exp_wb; v.exp_err = exp_err; v.exp_dst = exp_dst; v.exp_req = exp_req;
    return v;
  endfunction

  task automatic drive_m(input vec_t v);
    aluFinalM = v.alu; addPCM = v.pc; aluOutM = v.addr; wrtDataM = v.wdata;
    imm8M = v.imm; instructionM = v.instr;
    readEnM = (v.op == OP_RD); memWrtM = (v.op == OP_WR);
    wbDataSelM = v.sel; regWrtM = v.regwrt; wrtRegM = v.wreg; createDumpM = v.dump;
  endtask

  // Runs one instruction from posedge+1 to posedge+1 after it retires.
  // Timeline: request cycles 0..s (stalled 0..s-1, accepted at s), completion
  // at c = s+n, retirement at a = max(c, k) where istall is high for 0..k-1.
  task automatic run_instr(input vec_t v, input bit from_tab);
    bit          mis, issue;
    int          c, a, dst, req_cnt;
    logic [15:0] data_a, exp_wb;
    logic        exp_err;
    mis     = (v.op != OP_NONE) && v.addr[0];
    issue   = (v.op != OP_NONE) && !mis;
    c       = issue ? v.s + v.n : 0;
    a       = (c > v.k) ? c : v.k;
    dst     = 0;
    req_cnt = 0;
    data_a  = 16'h0000;
    for (int t = 0; t <= a; t++) begin
      drive_m(v);
      istall     = (t < v.k);
      memStall   = issue && (t < v.s);
      memDone    = issue && (t == c);
      memErr     = issue && (t == c) && v.ebit;
      memDataOut = (issue && t == c) ? v.rdata : 16'($urandom);
      if (t == a) data_a = memDataOut;
      #4;
      chk("memRd", memRd, issue && v.op == OP_RD && t <= v.s);
      chk("memWr", memWr, issue && v.op == OP_WR && t <= v.s);
      if (memRd || memWr) req_cnt++;
      if (issue && t <= v.s) begin
        chk("memAddr", memAddr, v.addr);
        chk("memDataIn", memDataIn, v.wdata);
      end
      chk("dstall", dstall, t < c);
      if (dstall) dst++;
      @(posedge clk);
      #1;
      if (t < a) chk("bubble", {regWrtW, createDumpW, errW, wbDataW}, {3'b000, prev_wb});
    end
    case (v.sel)
      2'd0:    exp_wb = issue ? v.rdata : data_a;
      2'd1:    exp_wb = v.alu;
      2'd2:    exp_wb = v.pc;
      default: exp_wb = v.imm;
    endcase
    exp_err = mis | (issue & v.ebit);
    chk("wbDataW", wbDataW, exp_wb);
    chk("regWrtW", regWrtW, v.regwrt);
    chk("wrtRegW", wrtRegW, v.wreg);
    chk("createDumpW", createDumpW, v.dump);
    chk("errW", errW, exp_err);
    chk("instructionW", instructionW, v.instr);
    if (from_tab) begin
      chk("tab_wbDataW", wbDataW, v.exp_wb);
      chk("tab_errW", errW, v.exp_err);
      chk("tab_dstall_cycles", dst, v.exp_dst);
      chk("tab_req_cycles", req_cnt, v.exp_req);
    end
    prev_wb = exp_wb;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op       addr      sel alu       pc        imm       rdata     s  n  k  e  reg exp_wb    err dst req
    tab[0] = mk(OP_NONE, 16'h0000, 1, 16'h1234, 16'h0002, 16'h0003, 16'h0000, 0, 0, 0, 0, 3, 16'h1234, 0, 0, 0);
    tab[1] = mk(OP_RD,   16'h0040, 0, 16'h1111, 16'h2222, 16'h3333, 16'hBEEF, 0, 0, 0, 0, 5, 16'hBEEF, 0, 0, 1);
    tab[2] = mk(OP_RD,   16'h0042, 0, 16'h1111, 16'h2222, 16'h3333, 16'hCAFE, 0, 4, 0, 0, 2, 16'hCAFE, 0, 4, 1);
    tab[3] = mk(OP_WR,   16'h0080, 1, 16'h5555, 16'h2222, 16'h3333, 16'h0000, 0, 0, 4, 0, 1, 16'h5555, 0, 0, 1);
    tab[4] = mk(OP_RD,   16'h0041, 2, 16'h1111, 16'h0102, 16'h3333, 16'h0000, 0, 0, 0, 0, 4, 16'h0102, 1, 0, 0);
    tab[5] = mk(OP_RD,   16'h0044, 0, 16'h1111, 16'h2222, 16'h3333, 16'hD00D, 0, 0, 0, 1, 7, 16'hD00D, 1, 0, 1);
    tab[6] = mk(OP_RD,   16'h0046, 3, 16'h1111, 16'h2222, 16'h00A7, 16'h4444, 2, 3, 2, 0, 1, 16'h00A7, 0, 5, 3);
    tab[7] = mk(OP_RD,   16'h0048, 0, 16'h1111, 16'h2222, 16'h3333, 16'h7777, 0, 2, 6, 0, 2, 16'h7777, 0, 2, 1);
    tab[8] = mk(OP_WR,   16'h004A, 2, 16'h1111, 16'h0BAD, 16'h3333, 16'h0000, 0, 3, 0, 1, 6, 16'h0BAD, 1, 3, 1);
    tab[9] = mk(OP_NONE, 16'h0000, 1, 16'h9999, 16'h2222, 16'h3333, 16'h0000, 0, 0, 3, 0, 0, 16'h9999, 0, 0, 0);

    // Reset with an aligned, stalled load presented: everything must stay quiet
    rst = 1'b0;
    drive_m(tab[1]);
    istall = 1'b0; memStall = 1'b1; memDone = 1'b0; memErr = 1'b0; memDataOut = 16'h0000;
    #3;
    chk("rst_memRd", memRd, 0);
    chk("rst_memWr", memWr, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memDataIn", memDataIn, 0);
    chk("rst_dstall", dstall, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_W_data", {wbDataW, instructionW}, 0);
    chk("rst_W_ctrl", {regWrtW, wrtRegW, createDumpW, errW}, 0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_instr(tab[i], 1'b1);

    // Reset in the middle of a miss, then a stray memDone afterwards
    rv = mk(OP_RD, 16'h0200, 0, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 0, 10, 0, 0, 1,
            16'h0000, 0, 0, 0);
    drive_m(rv);
    istall = 1'b0; memStall = 1'b0; memDone = 1'b0; memErr = 1'b0;
    #4;
    chk("wr_issue_memRd", memRd, 1);
    @(posedge clk); #1;
    #4;
    chk("wr_wait_memRd", memRd, 0);
    chk("wr_wait_dstall", dstall, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("wr_rst_memRd", memRd, 0);
    chk("wr_rst_dstall", dstall, 0);
    chk("wr_rst_W_data", {wbDataW, instructionW}, 0);
    chk("wr_rst_W_ctrl", {regWrtW, wrtRegW, createDumpW, errW}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    rv = mk(OP_NONE, 16'h0000, 1, 16'h4321, 16'h2222, 16'h3333, 16'h0000, 0, 0, 0, 0, 6,
            16'h4321, 0, 0, 0);
    drive_m(rv);
    memDone = 1'b1; memErr = 1'b1; memDataOut = 16'hEEEE;
    #4;
    chk("stray_dstall", dstall, 0);
    chk("stray_memRd", memRd, 0);
    @(posedge clk); #1;
    chk("stray_wbDataW", wbDataW, 16'h4321);
    chk("stray_errW", errW, 0);
    chk("stray_regWrtW", regWrtW, 1);
    prev_wb = 16'h4321;

    // Randomized scenarios
    for (int i = 0; i < 150; i++) begin
      rv.op     = 2'($urandom_range(0, 2));
      rv.addr   = 16'($urandom);
      rv.addr[0] = ($urandom_range(0, 7) == 0);
      rv.sel    = 2'($urandom_range(0, 3));
      rv.alu    = 16'($urandom);
      rv.pc     = 16'($urandom);
      rv.imm    = 16'($urandom);
      rv.wdata  = 16'($urandom);
      rv.instr  = 16'($urandom);
      rv.rdata  = 16'($urandom);
      rv.regwrt = 1'($urandom_range(0, 1));
      rv.wreg   = 3'($urandom_range(0, 7));
      rv.dump   = ($urandom_range(0, 9) == 0);
      rv.ebit   = ($urandom_range(0, 5) == 0);
      rv.s      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      rv.n      = int'($urandom_range(0, 4));
      rv.k      = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
      run_instr(rv, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
